// File: rtl/axil_ram_slave_if.sv
// AXI-Lite bus bundle for axil_ram_slave: AW, W, B, AR and R channels.
interface axil_ram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_ram_slave.sv
// AXI-Lite slave RAM. AW and W are captured in independent holding registers
// and committed together once the B channel can take a response. Reads have a
// one-cycle registered latency. Out-of-range accesses answer SLVERR and leave
// memory untouched.
module axil_ram_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           MEM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic             clk,
  input logic             rst,
  axil_ram_slave_if.slave s_axil
);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  localparam int unsigned BYTE_W = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned SPAN   = MEM_WORDS * STRB_WIDTH;

  // One extra bit so BASE_ADDR + SPAN cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH + 1)'(SPAN);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Write holding registers and B channel state
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;

  // R channel state
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_e                 rresp_q, rresp_d;

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_off, rd_off;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic                  unused_bits;

  // Address decode for the latched write address and the live read address
  always_comb begin
    wr_off      = aw_addr_q - BASE_ADDR;
    rd_off      = s_axil.araddr - BASE_ADDR;
    wr_idx      = wr_off[BYTE_W +: IDX_W];
    rd_idx      = rd_off[BYTE_W +: IDX_W];
    wr_in_range = ({1'b0, aw_addr_q} >= RANGE_LO) && ({1'b0, aw_addr_q} < RANGE_HI);
    rd_in_range = ({1'b0, s_axil.araddr} >= RANGE_LO) && ({1'b0, s_axil.araddr} < RANGE_HI);
  end

  // Protection bits and the byte-lane / high offset bits carry no meaning here.
  assign unused_bits = ^{s_axil.awprot, s_axil.arprot, wr_off, rd_off};

  // Ready outputs come only from state and the response-channel readies.
  assign s_axil.awready = !aw_full_q;
  assign s_axil.wready  = !w_full_q;
  assign s_axil.arready = !rvalid_q || s_axil.rready;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  // Write path: capture AW/W independently, commit when both held and B is free
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    aw_fire = s_axil.awvalid && !aw_full_q;
    w_fire  = s_axil.wvalid && !w_full_q;
    commit  = aw_full_q && w_full_q && (!bvalid_q || s_axil.bready);

    // A commit needs both registers full and a capture needs its register
    // empty, so the clear below never collides with a capture of the same one.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axil.bready) begin
      bvalid_d = 1'b0;
    end

    if (aw_fire) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil.awaddr;
    end
    if (w_fire) begin
      w_full_d = 1'b1;
      w_data_d = s_axil.wdata;
      w_strb_d = s_axil.wstrb;
    end
  end

  // Read path: one-cycle registered response, held until rready
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    ar_fire = s_axil.arvalid && (!rvalid_q || s_axil.rready);

    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? mem[rd_idx] : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Byte-masked memory write; the read above samples the pre-write contents
  always_ff @(posedge clk) begin
    if (commit && wr_in_range) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb_q[i]) begin
          mem[wr_idx][i*8 +: 8] <= w_data_q[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave with a queue-based response scoreboard.
module tb_axil_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [1:0]  b_e;
  logic [33:0] r_e;
  logic        rd_done;
  int unsigned c0;

  axil_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_ram_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_WORDS (256),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axil(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: handshake did not occur within 50 cycles", name);
  endtask

  // Scoreboard monitor: pop and compare whenever a response is transferred
  always @(negedge clk) begin
    if (rst && bus.bvalid && bus.bready) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: got bresp %b, required no response", bus.bresp);
      end else begin
        b_e = exp_b.pop_front();
        check("bresp", 64'(bus.bresp), 64'(b_e));
      end
    end
    if (rst && bus.rvalid && bus.rready) begin
      if (exp_r.size() == 0) begin
        n_checks++;
        $display("FAIL r_unexpected: got rdata %h, required no response", bus.rdata);
      end else begin
        r_e = exp_r.pop_front();
        check("rdata", 64'(bus.rdata), 64'(r_e[31:0]));
        check("rresp", 64'(bus.rresp), 64'(r_e[33:32]));
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int unsigned n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.awready) break;
      if (++n > 50) begin timeout("aw_handshake"); break; end
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.wready) break;
      if (++n > 50) begin timeout("w_handshake"); break; end
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int unsigned n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.arready) break;
      if (++n > 50) begin timeout("ar_handshake"); break; end
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic read_word(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back({resp, d});
    send_ar(a);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (exp_b.size() != 0 || exp_r.size() != 0) begin
      @(posedge clk);
      if (++n > 50) begin timeout("drain"); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_awready", 64'(bus.awready), 1);
    check("rst_wready",  64'(bus.wready),  1);
    check("rst_bvalid",  64'(bus.bvalid),  0);
    check("rst_rvalid",  64'(bus.rvalid),  0);
    check("rst_rdata",   64'(bus.rdata),   0);

    // AW and W together, then read back; check write/read latency
    write_word(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    check("b_lat_handshake_edge", 64'(bus.bvalid), 0);
    @(posedge clk); #1;
    check("b_lat_commit_edge", 64'(bus.bvalid), 1);
    wait_idle();
    read_word(32'h10, 32'hDEADBEEF, 2'b00);
    check("r_lat_one_edge", 64'(bus.rvalid), 1);
    wait_idle();

    // W leads AW by three cycles, then a strobed partial write
    exp_b.push_back(2'b00);
    send_w(32'h11223344, 4'hF);
    check("w_lead_wready", 64'(bus.wready), 0);
    check("w_lead_awready", 64'(bus.awready), 1);
    repeat (2) @(posedge clk);
    #1;
    check("w_lead_no_commit", 64'(bus.bvalid), 0);
    send_aw(32'h20);
    wait_idle();
    write_word(32'h20, 32'hAABBCCDD, 4'b0101, 2'b00);
    wait_idle();
    read_word(32'h20, 32'h11BB33DD, 2'b00);
    wait_idle();

    // Out of range: SLVERR, zero data, word 0 untouched
    write_word(32'h0, 32'h0BADF00D, 4'hF, 2'b00);
    wait_idle();
    write_word(32'h400, 32'h55AA55AA, 4'hF, 2'b10);
    wait_idle();
    read_word(32'h400, 32'h0, 2'b10);
    wait_idle();
    read_word(32'h0, 32'h0BADF00D, 2'b00);
    wait_idle();

    // Zero strobe: OKAY and no change
    write_word(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
    wait_idle();
    read_word(32'h10, 32'hDEADBEEF, 2'b00);
    wait_idle();

    // Read and write commit to the same word on one edge: old data returned
    write_word(32'h60, 32'h00000001, 4'hF, 2'b00);
    wait_idle();
    write_word(32'h60, 32'h00000002, 4'hF, 2'b00);
    read_word(32'h60, 32'h00000001, 2'b00);
    wait_idle();
    read_word(32'h60, 32'h00000002, 2'b00);
    wait_idle();

    // B back-pressure: second write parks in the holding registers
    bus.bready = 1'b0;
    write_word(32'h30, 32'hCAFE0001, 4'hF, 2'b00);
    write_word(32'h34, 32'hCAFE0002, 4'hF, 2'b00);
    check("bp_awready", 64'(bus.awready), 0);
    check("bp_wready",  64'(bus.wready),  0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_bvalid_held", 64'(bus.bvalid), 1);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("bp_no_bubble", 64'(bus.bvalid), 1);
    check("bp_regs_freed", 64'(bus.awready), 1);
    @(posedge clk); #1;
    bus.bready = 1'b1;
    wait_idle();
    read_word(32'h30, 32'hCAFE0001, 2'b00);
    read_word(32'h34, 32'hCAFE0002, 2'b00);
    wait_idle();

    // Eight back-to-back reads, then eight with rready toggling
    for (int i = 0; i < 8; i++) write_word(32'h80 + 32'(i) * 4, 32'hA5A50000 | 32'(i), 4'hF, 2'b00);
    wait_idle();
    c0 = cyc;
    for (int i = 0; i < 8; i++) read_word(32'h80 + 32'(i) * 4, 32'hA5A50000 | 32'(i), 2'b00);
    check("rd_b2b_cycles", 64'(cyc - c0), 8);
    wait_idle();
    rd_done = 1'b0;
    bus.rready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) read_word(32'h80 + 32'(i) * 4, 32'hA5A50000 | 32'(i), 2'b00);
        rd_done = 1'b1;
      end
      begin
        while (!rd_done) begin
          @(posedge clk); #1;
          bus.rready = ~bus.rready;
        end
      end
    join
    bus.rready = 1'b1;
    wait_idle();

    // Reset with AW held but no W: nothing may be written afterwards
    write_word(32'h50, 32'h12345678, 4'hF, 2'b00);
    wait_idle();
    send_aw(32'h50);
    check("mid_aw_held", 64'(bus.awready), 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_awready", 64'(bus.awready), 1);
    check("mid_rst_bvalid",  64'(bus.bvalid),  0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_w(32'hFFFFFFFF, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_bvalid", 64'(bus.bvalid), 0);
    read_word(32'h50, 32'h12345678, 2'b00);
    wait_idle();

    check("sb_drained", 64'(exp_b.size() + exp_r.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
